clk_div_monitor: RTL and testbench
==================================

# clk_div_monitor

Checker for a divided clock: the sink side of a clock divider. The block samples a divided clock as synchronous data in the fast `clk` domain and detects its edges. It measures the high phase, low phase and full period in `clk` cycles, and declares lock once the period has matched the expected divide ratio several times in a row. It sits next to a divider output, for example a divide-by-6, and flags wrong ratios and stalls to the system and to testbenches.

## Interface
Parameters:
- `CNT_W`, default 8: width of the phase counter and of the `high_len`/`low_len` outputs.
- `EXP_DIV`, default 6: expected period in `clk` cycles. Range 2..2^CNT_W.
- `LOCK_CNT`, default 4: number of consecutive matching periods required for lock. Range 1..15.
- `TIMEOUT`, default 32: number of cycles without an edge that declares a stall. Range 2..2^CNT_W-1, and must be greater than EXP_DIV.

Ports:
- `clk`, input, 1 bit: fast reference clock. All logic runs on its rising edge.
- `reset`, input, 1 bit: synchronous, active-high reset.
- `clk_in`, input, 1 bit: divided clock under test, generated synchronously to `clk`.
- `high_len`, output, CNT_W bits: last measured high phase, in cycles.
- `low_len`, output, CNT_W bits: last measured low phase, in cycles.
- `period`, output, CNT_W+1 bits: last measured full period. Equal to the `high_len` + `low_len` pair that completed it.
- `period_valid`, output, 1 bit: one-cycle pulse when `period` updates.
- `locked`, output, 1 bit: level. High while lock holds.
- `err`, output, 1 bit: one-cycle pulse when a measured period differs from EXP_DIV.
- `stall`, output, 1 bit: level. High while `clk_in` has shown no edge for TIMEOUT cycles.

## Operation
- **Edge detect.** `prev` is a registered copy of `clk_in`.
  - rise = `clk_in` & ~`prev`; fall = ~`clk_in` & `prev`.
  - The `primed` flag clears on reset. The first cycle after reset only loads `prev` and detects no edge.
- **Phase counter `ph_cnt`.**
  - Loads 1 on an edge cycle; otherwise increments.
  - Saturates at TIMEOUT. It never wraps.
- **States:** IDLE, MEAS_H, MEAS_L.
  - IDLE: wait for a rise, then go to MEAS_H. A fall in IDLE is ignored.
  - MEAS_H: on a fall, `high_len` <= `ph_cnt`, then go to MEAS_L.
  - MEAS_L: on a rise:
    - `low_len` <= `ph_cnt`.
    - `period` <= `high_len` + `ph_cnt`, zero-extended to CNT_W+1 bits.
    - `period_valid` <= 1.
    - Go to MEAS_H.
  - Any state: if `ph_cnt` == TIMEOUT and the cycle has no edge:
    - `stall` <= 1, `locked` <= 0, match count <= 0.
    - Go to IDLE.
- **Lock tracking** (`match` counter, 4 bits), evaluated on every `period_valid` event:
  - Period equals EXP_DIV: `match` increments, saturating at LOCK_CNT. `locked` <= 1 when the new value equals LOCK_CNT.
  - Period differs from EXP_DIV: `match` <= 0, `locked` <= 0, `err` pulses for one cycle.
- **Stall exit.** `stall` clears on the next rise, which starts MEAS_H. The first period after a stall needs a full high phase and a full low phase before `period_valid`.
- **First measurement.** No `period_valid` is produced until a rise, a fall and a second rise have all been seen after reset or after a stall.

## Timing
- Reset values:
  - `high_len`, `low_len`, `period`: 0.
  - `period_valid`, `locked`, `err`, `stall`: 0.
  - state: IDLE; `match`: 0; `primed`: 0; `prev`: 0.
- All outputs are registered.
- Let cycle R be the `clk` edge at which a 1 on `clk_in` is first sampled after a 0:
  - `period_valid`, `period` and `low_len` are visible from R+1.
  - `locked` and `err` change in the same cycle as `period_valid`, from R+1.
- `high_len` is visible from F+1, where F is the edge at which the falling value is first sampled.
- Measured lengths equal the number of consecutive samples at that level. A 3-high/3-low waveform gives `high_len`=3, `low_len`=3, `period`=6.
- The stall event is registered on the cycle where `ph_cnt` is already TIMEOUT, so `stall` rises TIMEOUT+1 cycles after the last edge.
- Edge and timeout in the same cycle: the edge wins. No stall is raised.
- `reset` asserted mid-period: on the next edge, every register returns to its reset value and any partial measurement is discarded.
- `clk_in` that changes every cycle (high=1, low=1) is legal and gives `period`=2.

## Test plan
- **Divide-by-6 source.** Drive `clk_in` 3 high / 3 low, with the default EXP_DIV=6 and LOCK_CNT=4.
  - `period_valid` pulses every 6 cycles with `period`=6, `high_len`=3 and `low_len`=3.
  - `locked` rises on the 4th pulse.
  - `err` never pulses.
- **Wrong ratio after lock.** After lock, switch `clk_in` to a 4 high / 4 low waveform.
  - The first pulse reports `period`=8, with `err`=1 for one cycle and `locked`=0.
  - Every following pulse also reports `period`=8 and pulses `err`. `locked` stays 0.
  - Restoring 3/3 relocks after 4 periods.
- **Stall.** After lock, hold `clk_in` at 1.
  - `stall`=1 and `locked`=0, 33 cycles after the last edge.
  - Resume 3/3: `stall` clears at the first rise. The first `period_valid` comes one full period later with `period`=6.
- **Asymmetric duty.** Drive 2 high / 4 low.
  - `high_len`=2, `low_len`=4, `period`=6, then lock.
  - This confirms that duty cycle does not affect lock.
- **Reset mid-operation.** Assert `reset` for 1 cycle while locked and in MEAS_L.
  - All outputs are 0 on the next cycle.
  - `clk_in` held high across reset release produces no spurious rise. The first `period_valid` needs a full rise, fall, rise sequence.
- **Minimum period.** Set EXP_DIV=2 and toggle `clk_in` every cycle.
  - `period`=2 on every rise, and `locked` after 4 periods.

Source files
------------

// File: rtl/clk_div_monitor.sv
// clk_div_monitor
//
// Sink-side checker for a divided clock. clk_in is sampled as ordinary synchronous data in the
// clk domain. The block measures the high phase, the low phase and the full period of clk_in.
// It declares lock after LOCK_CNT consecutive periods equal to EXP_DIV, and it flags a stall
// when clk_in shows no edge for TIMEOUT cycles.
//
// Ports:
//   clk          in   fast reference clock, rising edge
//   reset        in   synchronous active-high reset
//   clk_in       in   divided clock under test (synchronous to clk)
//   high_len     out  last measured high phase, cycles        [CNT_W-1:0]
//   low_len      out  last measured low phase, cycles         [CNT_W-1:0]
//   period       out  last measured period (high + low)       [CNT_W:0]
//   period_valid out  one-cycle pulse when period updates
//   locked       out  level, lock currently held
//   err          out  one-cycle pulse on a period != EXP_DIV
//   stall        out  level, no clk_in edge for TIMEOUT cycles
module clk_div_monitor #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned EXP_DIV  = 6,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned TIMEOUT  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_in,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] low_len,
  output logic [CNT_W:0]   period,
  output logic             period_valid,
  output logic             locked,
  output logic             err,
  output logic             stall
);

  localparam int unsigned PerW = CNT_W + 1;
  localparam logic [PerW-1:0]  ExpDivW  = PerW'(EXP_DIV);
  localparam logic [CNT_W-1:0] TimeoutW = CNT_W'(TIMEOUT);
  localparam logic [3:0]       LockW    = 4'(LOCK_CNT);

  typedef enum logic [1:0] {
    StIdle,
    StMeasH,
    StMeasL
  } state_e;

  state_e           state_q, state_d;
  logic             prev_q, prev_d;
  logic             primed_q, primed_d;
  logic [CNT_W-1:0] ph_cnt_q, ph_cnt_d;
  logic [CNT_W-1:0] high_len_q, high_len_d;
  logic [CNT_W-1:0] low_len_q, low_len_d;
  logic [PerW-1:0]  period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             stall_q, stall_d;
  logic [3:0]       match_q, match_d;

  logic             rise, fall, edge_seen, timeout_hit;
  logic [PerW-1:0]  new_period;
  logic [3:0]       match_inc;

  // No edge is reported until prev holds a real sample of clk_in.
  assign rise      = primed_q & clk_in & ~prev_q;
  assign fall      = primed_q & ~clk_in & prev_q;
  assign edge_seen = rise | fall;

  // An edge in the same cycle as the timeout wins.
  assign timeout_hit = (ph_cnt_q == TimeoutW) && !edge_seen;

  // On a rise in MEAS_L, ph_cnt_q holds the completed low phase length.
  assign new_period = {1'b0, high_len_q} + {1'b0, ph_cnt_q};
  assign match_inc  = (match_q == LockW) ? match_q : match_q + 4'd1;

  always_comb begin
    state_d        = state_q;
    prev_d         = clk_in;
    primed_d       = 1'b1;
    high_len_d     = high_len_q;
    low_len_d      = low_len_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    locked_d       = locked_q;
    err_d          = 1'b0;
    stall_d        = stall_q;
    match_d        = match_q;

    // Phase counter restarts at 1 on the first sample of a new level and saturates.
    if (edge_seen) begin
      ph_cnt_d = CNT_W'(1);
    end else if (ph_cnt_q != TimeoutW) begin
      ph_cnt_d = ph_cnt_q + CNT_W'(1);
    end else begin
      ph_cnt_d = ph_cnt_q;
    end

    if (timeout_hit) begin
      stall_d  = 1'b1;
      locked_d = 1'b0;
      match_d  = 4'd0;
      state_d  = StIdle;
    end else begin
      if (rise) begin
        stall_d = 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (rise) begin
            state_d = StMeasH;
          end
        end
        StMeasH: begin
          if (fall) begin
            high_len_d = ph_cnt_q;
            state_d    = StMeasL;
          end
        end
        StMeasL: begin
          if (rise) begin
            low_len_d      = ph_cnt_q;
            period_d       = new_period;
            period_valid_d = 1'b1;
            state_d        = StMeasH;
            if (new_period == ExpDivW) begin
              match_d = match_inc;
              if (match_inc == LockW) begin
                locked_d = 1'b1;
              end
            end else begin
              match_d  = 4'd0;
              locked_d = 1'b0;
              err_d    = 1'b1;
            end
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      prev_q         <= 1'b0;
      primed_q       <= 1'b0;
      ph_cnt_q       <= '0;
      high_len_q     <= '0;
      low_len_q      <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      err_q          <= 1'b0;
      stall_q        <= 1'b0;
      match_q        <= 4'd0;
    end else begin
      state_q        <= state_d;
      prev_q         <= prev_d;
      primed_q       <= primed_d;
      ph_cnt_q       <= ph_cnt_d;
      high_len_q     <= high_len_d;
      low_len_q      <= low_len_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      err_q          <= err_d;
      stall_q        <= stall_d;
      match_q        <= match_d;
    end
  end

  assign high_len     = high_len_q;
  assign low_len      = low_len_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign err          = err_q;
  assign stall        = stall_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor. Instance u_dut uses the default divide-by-6 setup;
// instance u_dut2 uses EXP_DIV=2 for the minimum-period case. Inputs change on the falling
// edge of clk and outputs are sampled 1 time unit after the rising edge.
module tb_clk_div_monitor;

  logic       clk;
  logic       reset;
  logic       clk_in;
  logic       clk_in2;

  logic [7:0] high_len, low_len, high_len2, low_len2;
  logic [8:0] period, period2;
  logic       period_valid, locked, err, stall;
  logic       period_valid2, locked2, err2, stall2;

  int checks;
  int failures;
  int spurious;

  clk_div_monitor #(
    .CNT_W   (8),
    .EXP_DIV (6),
    .LOCK_CNT(4),
    .TIMEOUT (32)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .clk_in      (clk_in),
    .high_len    (high_len),
    .low_len     (low_len),
    .period      (period),
    .period_valid(period_valid),
    .locked      (locked),
    .err         (err),
    .stall       (stall)
  );

  clk_div_monitor #(
    .CNT_W   (8),
    .EXP_DIV (2),
    .LOCK_CNT(4),
    .TIMEOUT (32)
  ) u_dut2 (
    .clk         (clk),
    .reset       (reset),
    .clk_in      (clk_in2),
    .high_len    (high_len2),
    .low_len     (low_len2),
    .period      (period2),
    .period_valid(period_valid2),
    .locked      (locked2),
    .err         (err2),
    .stall       (stall2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input logic v);
    @(negedge clk);
    clk_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic tick2(input logic v);
    @(negedge clk);
    clk_in2 = v;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".high_len"}, 32'(high_len), 0);
    check_eq({tag, ".low_len"}, 32'(low_len), 0);
    check_eq({tag, ".period"}, 32'(period), 0);
    check_eq({tag, ".period_valid"}, 32'(period_valid), 0);
    check_eq({tag, ".locked"}, 32'(locked), 0);
    check_eq({tag, ".err"}, 32'(err), 0);
    check_eq({tag, ".stall"}, 32'(stall), 0);
  endtask

  // One clk_in period starting with its rise. The rise reports the previous period, so the
  // expected pulse values describe that one; high_len is checked after this period's fall.
  task automatic do_period(input int hi, input int lo, input logic exp_pv, input int exp_per,
                           input int exp_ll, input logic exp_lock, input logic exp_err);
    spurious = 0;
    tick(1'b1);
    check_eq("rise.period_valid", 32'(period_valid), 32'(exp_pv));
    check_eq("rise.locked", 32'(locked), 32'(exp_lock));
    check_eq("rise.err", 32'(err), 32'(exp_err));
    check_eq("rise.stall", 32'(stall), 0);
    if (exp_pv) begin
      check_eq("rise.period", 32'(period), 32'(exp_per));
      check_eq("rise.low_len", 32'(low_len), 32'(exp_ll));
    end
    for (int i = 1; i < hi; i++) begin
      tick(1'b1);
      if (period_valid || err) spurious++;
    end
    for (int i = 0; i < lo; i++) begin
      tick(1'b0);
      if (period_valid || err) spurious++;
      if (i == 0) check_eq("fall.high_len", 32'(high_len), 32'(hi));
    end
    check_eq("quiet_between_rises", 32'(spurious), 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    clk_in   = 1'b0;
    clk_in2  = 1'b0;
    tick(1'b0);
    tick(1'b0);
    check_all_zero("reset");
    reset = 1'b0;
    tick(1'b0);
    tick(1'b0);

    // Divide-by-6, 3/3: lock on the 4th pulse.
    do_period(3, 3, 1'b0, 0, 0, 1'b0, 1'b0);
    do_period(3, 3, 1'b1, 6, 3, 1'b0, 1'b0);
    do_period(3, 3, 1'b1, 6, 3, 1'b0, 1'b0);
    do_period(3, 3, 1'b1, 6, 3, 1'b0, 1'b0);
    do_period(3, 3, 1'b1, 6, 3, 1'b1, 1'b0);

    // Wrong ratio 4/4 after lock, then relock on 3/3.
    do_period(4, 4, 1'b1, 6, 3, 1'b1, 1'b0);
    do_period(4, 4, 1'b1, 8, 4, 1'b0, 1'b1);
    do_period(4, 4, 1'b1, 8, 4, 1'b0, 1'b1);
    do_period(3, 3, 1'b1, 8, 4, 1'b0, 1'b1);
    do_period(3, 3, 1'b1, 6, 3, 1'b0, 1'b0);
    do_period(3, 3, 1'b1, 6, 3, 1'b0, 1'b0);
    do_period(3, 3, 1'b1, 6, 3, 1'b0, 1'b0);
    do_period(3, 3, 1'b1, 6, 3, 1'b1, 1'b0);

    // Stall: last edge is this rise, then clk_in held high.
    tick(1'b1);
    check_eq("stall.last_rise_pv", 32'(period_valid), 1);
    check_eq("stall.last_rise_period", 32'(period), 6);
    check_eq("stall.last_rise_locked", 32'(locked), 1);
    repeat (31) tick(1'b1);
    check_eq("stall.before_timeout", 32'(stall), 0);
    check_eq("stall.locked_before", 32'(locked), 1);
    tick(1'b1);
    check_eq("stall.asserted", 32'(stall), 1);
    check_eq("stall.locked_dropped", 32'(locked), 0);
    repeat (3) tick(1'b0);
    check_eq("stall.held_over_fall", 32'(stall), 1);
    do_period(3, 3, 1'b0, 0, 0, 1'b0, 1'b0);
    do_period(3, 3, 1'b1, 6, 3, 1'b0, 1'b0);

    // Asymmetric duty 2/4 still counts toward lock.
    do_period(2, 4, 1'b1, 6, 3, 1'b0, 1'b0);
    do_period(2, 4, 1'b1, 6, 4, 1'b0, 1'b0);
    do_period(2, 4, 1'b1, 6, 4, 1'b1, 1'b0);

    // Reset while locked in MEAS_L, clk_in held high across release.
    reset = 1'b1;
    tick(1'b1);
    check_all_zero("midreset");
    reset = 1'b0;
    repeat (4) tick(1'b1);
    check_eq("midreset.no_pv", 32'(period_valid), 0);
    check_eq("midreset.high_len", 32'(high_len), 0);
    repeat (3) tick(1'b0);
    check_eq("midreset.fall_ignored", 32'(high_len), 0);
    do_period(3, 3, 1'b0, 0, 0, 1'b0, 1'b0);
    do_period(3, 3, 1'b1, 6, 3, 1'b0, 1'b0);

    // Minimum period on the EXP_DIV=2 instance.
    reset = 1'b1;
    tick2(1'b0);
    reset = 1'b0;
    tick2(1'b0);
    tick2(1'b0);
    tick2(1'b1);
    check_eq("min.first_rise_pv", 32'(period_valid2), 0);
    for (int i = 1; i <= 4; i++) begin
      tick2(1'b0);
      tick2(1'b1);
      check_eq("min.pv", 32'(period_valid2), 1);
      check_eq("min.period", 32'(period2), 2);
      check_eq("min.high_len", 32'(high_len2), 1);
      check_eq("min.low_len", 32'(low_len2), 1);
      check_eq("min.err", 32'(err2), 0);
      check_eq("min.locked", 32'(locked2), 32'(i == 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
